// File: rtl/integer_register_write_stage_pkg.sv
// Shared pipeline types for the integer register-write stage and its
// predictor-update queue.
package PipelineTypes;

  localparam int unsigned DEFAULT_INT_ISSUE_WIDTH    = 2;
  localparam int unsigned DEFAULT_BR_UPD_QUEUE_DEPTH = 4;

  localparam int unsigned PREG_NUM_WIDTH          = 6;
  localparam int unsigned PREG_DATA_WIDTH         = 32;
  localparam int unsigned ACTIVE_LIST_INDEX_WIDTH = 5;
  localparam int unsigned ADDR_WIDTH              = 16;

  typedef logic [PREG_NUM_WIDTH-1:0]          PRegNum;
  typedef logic [PREG_DATA_WIDTH-1:0]         PRegDataPath;
  typedef logic [ACTIVE_LIST_INDEX_WIDTH-1:0] ActiveListIndexPath;
  typedef logic [ADDR_WIDTH-1:0]              AddrPath;
  typedef logic [$clog2(DEFAULT_BR_UPD_QUEUE_DEPTH)-1:0] BrUpdQueueIndexPath;

  typedef struct packed {
    logic               writeReg;
    PRegNum             dstPhyReg;
    ActiveListIndexPath activeListPtr;
  } IntQueueData;

  typedef struct packed {
    logic        valid;
    PRegDataPath data;
  } PRegDataOut;

  typedef struct packed {
    logic    valid;
    logic    taken;
    AddrPath brAddr;
    AddrPath nextAddr;
  } BranchResult;

  typedef struct packed {
    logic        valid;
    IntQueueData intQueueData;
    PRegDataOut  dataOut;
    BranchResult brResult;
    logic        brMissPred;
  } IntegerRegisterWriteStageRegPath;

endpackage

// File: rtl/integer_register_write_stage_branch_update_queue.sv
// BranchUpdateQueue: multi-push (ascending lane order), single-pop FIFO
// feeding branch results to the predictor.
module BranchUpdateQueue
  import PipelineTypes::*;
#(
  parameter int unsigned PUSH_WIDTH = DEFAULT_INT_ISSUE_WIDTH,
  parameter int unsigned DEPTH      = DEFAULT_BR_UPD_QUEUE_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PUSH_WIDTH-1:0]        push,
  input  BranchResult                  pushData [PUSH_WIDTH],
  input  logic                         pop,
  output BranchResult                  headData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef logic [IDX_W-1:0] Index;
  typedef logic [CNT_W-1:0] Count;

  BranchResult entries [DEPTH];
  Index        headPtr;
  Index        tailPtr;
  Index        slot [PUSH_WIDTH];
  Count        numPush;
  logic        doPop;

  // Each pushing lane takes the next free slot after all lower pushing lanes.
  always_comb begin
    numPush = '0;
    for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
      slot[i] = tailPtr + Index'(numPush);
      if (push[i]) numPush = numPush + Count'(1);
    end
  end

  assign doPop    = pop && (count != '0);
  assign headData = entries[headPtr];

  // Entry storage; contents are meaningless while not counted, so no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < PUSH_WIDTH; i++) begin
      if (push[i]) entries[slot[i]] <= pushData[i];
    end
  end

  // Pointers wrap naturally modulo the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      tailPtr <= tailPtr + Index'(numPush);
      if (doPop) headPtr <= headPtr + Index'(1);
      count   <= count + numPush - Count'(doPop);
    end
  end

endmodule

// File: rtl/integer_register_write_stage.sv
// Integer register-write stage: RF write-back, active-list completion,
// mispredict recovery request and predictor-update queueing.
// Optional feature macro: RSD_INT_WB_PERF_COUNTER_EN (perfBrUpd/perfBrMiss).
module integer_register_write_stage
  import PipelineTypes::*;
#(
  parameter int unsigned INT_ISSUE_WIDTH    = DEFAULT_INT_ISSUE_WIDTH,
  parameter int unsigned BR_UPD_QUEUE_DEPTH = DEFAULT_BR_UPD_QUEUE_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            stall,
  input  logic                            clear,
  input  logic [INT_ISSUE_WIDTH-1:0]      flush,
  input  IntegerRegisterWriteStageRegPath prevStage [INT_ISSUE_WIDTH],
  output logic [INT_ISSUE_WIDTH-1:0]      rfWE,
  output PRegNum                          rfWAddr [INT_ISSUE_WIDTH],
  output PRegDataPath                     rfWData [INT_ISSUE_WIDTH],
  output logic [INT_ISSUE_WIDTH-1:0]      alDoneValid,
  output ActiveListIndexPath              alDonePtr [INT_ISSUE_WIDTH],
  output logic [INT_ISSUE_WIDTH-1:0]      alReplay,
  output logic                            brUpdValid,
  input  logic                            brUpdReady,
  output BranchResult                     brUpdData,
  output logic                            recoveryReq,
  output ActiveListIndexPath              recoveryPtr,
  output logic                            stallReq
`ifdef RSD_INT_WB_PERF_COUNTER_EN
  ,
  output logic [31:0]                     perfBrUpd,
  output logic [31:0]                     perfBrMiss
`endif
);

  localparam int unsigned CNT_W = $clog2(BR_UPD_QUEUE_DEPTH+1);

  IntegerRegisterWriteStageRegPath pipeReg [INT_ISSUE_WIDTH];
  logic [INT_ISSUE_WIDTH-1:0]      laneLive;
  logic [INT_ISSUE_WIDTH-1:0]      brPush;
  BranchResult                     brPushData [INT_ISSUE_WIDTH];
  logic [CNT_W-1:0]                queueCount;

  // Pipeline register: loads from execution stage unless stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < INT_ISSUE_WIDTH; i++) pipeReg[i].valid <= 1'b0;
    end else if (!stall) begin
      pipeReg <= prevStage;
    end
  end

  // Per-lane write-back, completion, push and recovery selection.
  always_comb begin
    rfWE        = '0;
    alDoneValid = '0;
    alReplay    = '0;
    brPush      = '0;
    laneLive    = '0;
    recoveryReq = 1'b0;
    recoveryPtr = '0;
    for (int unsigned i = 0; i < INT_ISSUE_WIDTH; i++) begin
      rfWAddr[i]    = pipeReg[i].intQueueData.dstPhyReg;
      rfWData[i]    = pipeReg[i].dataOut.data;
      alDonePtr[i]  = pipeReg[i].intQueueData.activeListPtr;
      brPushData[i] = pipeReg[i].brResult;
      laneLive[i]   = pipeReg[i].valid && !flush[i] && !clear && !stall && !rst;
      if (laneLive[i]) begin
        alDoneValid[i] = 1'b1;
        alReplay[i]    = !pipeReg[i].dataOut.valid;
        if (pipeReg[i].dataOut.valid) begin
          rfWE[i]   = pipeReg[i].intQueueData.writeReg;
          brPush[i] = pipeReg[i].brResult.valid;
          if (pipeReg[i].brMissPred && !recoveryReq) begin
            recoveryReq = 1'b1;
            recoveryPtr = pipeReg[i].intQueueData.activeListPtr;
          end
        end
      end
    end
  end

  BranchUpdateQueue #(
    .PUSH_WIDTH (INT_ISSUE_WIDTH),
    .DEPTH      (BR_UPD_QUEUE_DEPTH)
  ) brUpdQueue (
    .clk      (clk),
    .rst      (rst),
    .push     (brPush),
    .pushData (brPushData),
    .pop      (brUpdValid && brUpdReady),
    .headData (brUpdData),
    .count    (queueCount)
  );

  assign brUpdValid = !rst && (queueCount != '0);
  assign stallReq   = !rst &&
    ((CNT_W'(BR_UPD_QUEUE_DEPTH) - queueCount) < CNT_W'(INT_ISSUE_WIDTH));

`ifdef RSD_INT_WB_PERF_COUNTER_EN
  logic [31:0] numBrUpd;
  logic [31:0] numBrMiss;
  logic [32:0] brUpdSum;

  // Candidate push total with a carry bit used for saturation.
  always_comb begin
    brUpdSum = {1'b0, numBrUpd};
    for (int unsigned i = 0; i < INT_ISSUE_WIDTH; i++) begin
      if (brPush[i]) brUpdSum = brUpdSum + 33'd1;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      numBrUpd  <= '0;
      numBrMiss <= '0;
    end else begin
      numBrUpd <= brUpdSum[32] ? '1 : brUpdSum[31:0];
      if (recoveryReq && (numBrMiss != '1)) numBrMiss <= numBrMiss + 32'd1;
    end
  end

  assign perfBrUpd  = numBrUpd;
  assign perfBrMiss = numBrMiss;
`endif

endmodule

// File: tb/tb_integer_register_write_stage.sv
// Scoreboard bench for integer_register_write_stage (W=2, D=4).
module tb_integer_register_write_stage;
  import PipelineTypes::*;

  localparam int unsigned W = 2;
  localparam int unsigned D = 4;

  logic clk = 1'b0;
  logic rst, stall, clear, brUpdReady;
  logic [W-1:0] flush;
  IntegerRegisterWriteStageRegPath prevStage [W];
  logic [W-1:0] rfWE, alDoneValid, alReplay;
  PRegNum rfWAddr [W];
  PRegDataPath rfWData [W];
  ActiveListIndexPath alDonePtr [W];
  logic brUpdValid, recoveryReq, stallReq;
  BranchResult brUpdData;
  ActiveListIndexPath recoveryPtr;
`ifdef RSD_INT_WB_PERF_COUNTER_EN
  logic [31:0] perfBrUpd, perfBrMiss;
`endif

  always #5 clk = ~clk;

  integer_register_write_stage #(
    .INT_ISSUE_WIDTH    (W),
    .BR_UPD_QUEUE_DEPTH (D)
  ) dut (
    .clk (clk), .rst (rst), .stall (stall), .clear (clear), .flush (flush),
    .prevStage (prevStage),
    .rfWE (rfWE), .rfWAddr (rfWAddr), .rfWData (rfWData),
    .alDoneValid (alDoneValid), .alDonePtr (alDonePtr), .alReplay (alReplay),
    .brUpdValid (brUpdValid), .brUpdReady (brUpdReady), .brUpdData (brUpdData),
    .recoveryReq (recoveryReq), .recoveryPtr (recoveryPtr), .stallReq (stallReq)
`ifdef RSD_INT_WB_PERF_COUNTER_EN
    , .perfBrUpd (perfBrUpd), .perfBrMiss (perfBrMiss)
`endif
  );

  int nPass = 0;
  int nTotal = 0;
  logic [63:0] rfQ[$], alQ[$], brQ[$], recQ[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    nTotal++;
    $display("FAIL %s: got event %0h, expected none", name, act);
  endtask

  task automatic expectRf(input logic [7:0] lane, input PRegNum addr, input PRegDataPath d);
    rfQ.push_back(64'({lane, 2'b00, addr, d}));
  endtask
  task automatic expectAl(input logic [7:0] lane, input ActiveListIndexPath p, input logic rep);
    alQ.push_back(64'({lane, 3'b000, p, 7'b0, rep}));
  endtask
  task automatic expectBr(input logic [32:0] v);
    brQ.push_back(64'(v));
  endtask
  task automatic expectRec(input ActiveListIndexPath p);
    recQ.push_back(64'(p));
  endtask

  // Monitor: pops expected responses whenever the DUT presents an event.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < W; i++) begin
      if (rfWE[i]) begin
        if (rfQ.size() == 0) unexpected("rf_write", 64'({8'(i), 2'b00, rfWAddr[i], rfWData[i]}));
        else check("rf_write", 64'({8'(i), 2'b00, rfWAddr[i], rfWData[i]}), rfQ.pop_front());
      end
      if (alDoneValid[i]) begin
        if (alQ.size() == 0) unexpected("al_done", 64'({8'(i), 3'b000, alDonePtr[i], 7'b0, alReplay[i]}));
        else check("al_done", 64'({8'(i), 3'b000, alDonePtr[i], 7'b0, alReplay[i]}), alQ.pop_front());
      end else if (alReplay[i]) begin
        unexpected("al_replay_without_done", 64'(i));
      end
    end
    if (brUpdValid && brUpdReady) begin
      if (brQ.size() == 0) unexpected("br_upd", 64'({brUpdData.taken, brUpdData.brAddr, brUpdData.nextAddr}));
      else check("br_upd", 64'({brUpdData.taken, brUpdData.brAddr, brUpdData.nextAddr}), brQ.pop_front());
    end
    if (recoveryReq) begin
      if (recQ.size() == 0) unexpected("recovery", 64'(recoveryPtr));
      else check("recovery", 64'(recoveryPtr), recQ.pop_front());
    end
  end

  function automatic IntegerRegisterWriteStageRegPath mkOp(
    input logic wr, input PRegNum dst, input ActiveListIndexPath ptr,
    input logic dv, input PRegDataPath data, input logic bv, input AddrPath pc, input logic miss);
    IntegerRegisterWriteStageRegPath op;
    op.valid                      = 1'b1;
    op.intQueueData.writeReg      = wr;
    op.intQueueData.dstPhyReg     = dst;
    op.intQueueData.activeListPtr = ptr;
    op.dataOut.valid              = dv;
    op.dataOut.data               = data;
    op.brResult.valid             = bv;
    op.brResult.taken             = 1'b1;
    op.brResult.brAddr            = pc;
    op.brResult.nextAddr          = pc + 16'h0010;
    op.brMissPred                 = miss;
    return op;
  endfunction

  task automatic idleLanes();
    for (int i = 0; i < W; i++) prevStage[i] = '0;
  endtask

  // Loads the driven ops, then shows them for one cycle with the given controls.
  task automatic present(input logic [W-1:0] fl, input logic clr, input logic stl);
    @(posedge clk); #1;
    idleLanes();
    flush = fl; clear = clr; stall = stl;
    @(posedge clk); #1;
    flush = '0; clear = 1'b0; stall = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    for (int k = 0; k < 20 && brUpdValid; k++) begin
      @(posedge clk); #1;
    end
    check(name, 64'(brUpdValid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0; flush = '0; brUpdReady = 1'b1;
    idleLanes();
    @(posedge clk); #1;
    check("rst_rfWE", 64'(rfWE), 64'd0);
    check("rst_alDoneValid", 64'(alDoneValid), 64'd0);
    check("rst_alReplay", 64'(alReplay), 64'd0);
    check("rst_brUpdValid", 64'(brUpdValid), 64'd0);
    check("rst_recoveryReq", 64'(recoveryReq), 64'd0);
    check("rst_stallReq", 64'(stallReq), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Plain ALU write on lane 0.
    prevStage[0] = mkOp(1'b1, 6'd5, 5'd3, 1'b1, 32'h0000_1234, 1'b0, 16'h0, 1'b0);
    expectRf(0, 6'd5, 32'h0000_1234);
    expectAl(0, 5'd3, 1'b0);
    present('0, 1'b0, 1'b0);

    // Lane 0 without writeReg; lane 1 replayed mispredicted branch.
    prevStage[0] = mkOp(1'b0, 6'd10, 5'd2, 1'b1, 32'h0000_CAFE, 1'b0, 16'h0, 1'b0);
    prevStage[1] = mkOp(1'b1, 6'd6, 5'd4, 1'b0, 32'h0000_0066, 1'b1, 16'h0040, 1'b1);
    expectAl(0, 5'd2, 1'b0);
    expectAl(1, 5'd4, 1'b1);
    present('0, 1'b0, 1'b0);
    check("replay_no_push", 64'(brUpdValid), 64'd0);

    // Both lanes mispredicted: one recovery at the lower pointer, pushes in lane order.
    prevStage[0] = mkOp(1'b1, 6'd20, 5'd7, 1'b1, 32'h0000_0070, 1'b1, 16'h0007, 1'b1);
    prevStage[1] = mkOp(1'b1, 6'd21, 5'd9, 1'b1, 32'h0000_0090, 1'b1, 16'h0009, 1'b1);
    expectRf(0, 6'd20, 32'h0000_0070);
    expectRf(1, 6'd21, 32'h0000_0090);
    expectAl(0, 5'd7, 1'b0);
    expectAl(1, 5'd9, 1'b0);
    expectRec(5'd7);
    expectBr({1'b1, 16'h0007, 16'h0017});
    expectBr({1'b1, 16'h0009, 16'h0019});
    present('0, 1'b0, 1'b0);
    waitDrain("drain_after_dual_miss");

    // Fill the queue with the predictor not ready.
    brUpdReady = 1'b0;
    prevStage[0] = mkOp(1'b0, 6'd0, 5'd10, 1'b1, 32'h0, 1'b1, 16'h0100, 1'b0);
    prevStage[1] = mkOp(1'b0, 6'd0, 5'd11, 1'b1, 32'h0, 1'b1, 16'h0101, 1'b0);
    expectAl(0, 5'd10, 1'b0);
    expectAl(1, 5'd11, 1'b0);
    expectBr({1'b1, 16'h0100, 16'h0110});
    expectBr({1'b1, 16'h0101, 16'h0111});
    present('0, 1'b0, 1'b0);
    check("count2_stallReq", 64'(stallReq), 64'd0);
    check("count2_brUpdValid", 64'(brUpdValid), 64'd1);
    prevStage[0] = mkOp(1'b0, 6'd0, 5'd12, 1'b1, 32'h0, 1'b1, 16'h0102, 1'b0);
    prevStage[1] = mkOp(1'b0, 6'd0, 5'd13, 1'b1, 32'h0, 1'b1, 16'h0103, 1'b0);
    expectAl(0, 5'd12, 1'b0);
    expectAl(1, 5'd13, 1'b0);
    expectBr({1'b1, 16'h0102, 16'h0112});
    expectBr({1'b1, 16'h0103, 16'h0113});
    present('0, 1'b0, 1'b0);
    check("full_stallReq", 64'(stallReq), 64'd1);
    check("full_head", 64'(brUpdData.brAddr), 64'h0100);
    brUpdReady = 1'b1;
    @(posedge clk); #1;
    check("drain1_stallReq", 64'(stallReq), 64'd1);
    waitDrain("drain_full_queue");
    check("drained_stallReq", 64'(stallReq), 64'd0);

    // Flushed mispredicted branch on lane 0; lane 1 survives.
    prevStage[0] = mkOp(1'b1, 6'd25, 5'd5, 1'b1, 32'h0000_0025, 1'b1, 16'h0050, 1'b1);
    prevStage[1] = mkOp(1'b1, 6'd30, 5'd6, 1'b1, 32'h0000_0055, 1'b1, 16'h0055, 1'b0);
    expectRf(1, 6'd30, 32'h0000_0055);
    expectAl(1, 5'd6, 1'b0);
    expectBr({1'b1, 16'h0055, 16'h0065});
    present(2'b01, 1'b0, 1'b0);
    waitDrain("drain_after_flush");

    // Clear kills both lanes.
    prevStage[0] = mkOp(1'b1, 6'd1, 5'd1, 1'b1, 32'h0000_0011, 1'b1, 16'h0060, 1'b1);
    prevStage[1] = mkOp(1'b1, 6'd2, 5'd2, 1'b1, 32'h0000_0022, 1'b1, 16'h0061, 1'b0);
    present('0, 1'b1, 1'b0);
    check("clear_no_push", 64'(brUpdValid), 64'd0);

    // Stall holds the op; it completes exactly once afterwards.
    prevStage[0] = mkOp(1'b1, 6'd3, 5'd1, 1'b1, 32'h0000_BEEF, 1'b0, 16'h0, 1'b0);
    expectRf(0, 6'd3, 32'h0000_BEEF);
    expectAl(0, 5'd1, 1'b0);
    present('0, 1'b0, 1'b1);

    // Only lane 1 mispredicts: recovery pointer is lane 1's.
    prevStage[0] = mkOp(1'b0, 6'd0, 5'd11, 1'b1, 32'h0, 1'b1, 16'h0070, 1'b0);
    prevStage[1] = mkOp(1'b0, 6'd0, 5'd12, 1'b1, 32'h0, 1'b1, 16'h0071, 1'b1);
    expectAl(0, 5'd11, 1'b0);
    expectAl(1, 5'd12, 1'b0);
    expectRec(5'd12);
    expectBr({1'b1, 16'h0070, 16'h0080});
    expectBr({1'b1, 16'h0071, 16'h0081});
    present('0, 1'b0, 1'b0);
    waitDrain("drain_after_lane1_miss");

    // Reset with three queued entries discards them.
    brUpdReady = 1'b0;
    prevStage[0] = mkOp(1'b0, 6'd0, 5'd20, 1'b1, 32'h0, 1'b1, 16'h0200, 1'b0);
    prevStage[1] = mkOp(1'b0, 6'd0, 5'd21, 1'b1, 32'h0, 1'b1, 16'h0201, 1'b0);
    expectAl(0, 5'd20, 1'b0);
    expectAl(1, 5'd21, 1'b0);
    present('0, 1'b0, 1'b0);
    prevStage[0] = mkOp(1'b0, 6'd0, 5'd22, 1'b1, 32'h0, 1'b1, 16'h0202, 1'b0);
    expectAl(0, 5'd22, 1'b0);
    present('0, 1'b0, 1'b0);
    check("count3_stallReq", 64'(stallReq), 64'd1);
    rst = 1'b1;
    #1;
    check("in_rst_stallReq", 64'(stallReq), 64'd0);
    check("in_rst_brUpdValid", 64'(brUpdValid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("post_rst_brUpdValid", 64'(brUpdValid), 64'd0);
    brUpdReady = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    check("rfQ_empty", 64'(rfQ.size()), 64'd0);
    check("alQ_empty", 64'(alQ.size()), 64'd0);
    check("brQ_empty", 64'(brQ.size()), 64'd0);
    check("recQ_empty", 64'(recQ.size()), 64'd0);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
